// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame/oversampling constants.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned MID_TICKS = 8;
    localparam int unsigned BIT_TICKS = 16;

    localparam int unsigned TICK_CW = $clog2(BIT_TICKS);
    localparam int unsigned BIT_CW  = $clog2(DATA_BITS);

    // Terminal counts used by both cores
    localparam logic [TICK_CW-1:0] MID_LAST  = TICK_CW'(MID_TICKS - 1);
    localparam logic [TICK_CW-1:0] BIT_LAST  = TICK_CW'(BIT_TICKS - 1);
    localparam logic [BIT_CW-1:0]  DATA_LAST = BIT_CW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick generator shared by the RX and TX cores.
module uart_baud_tick #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..DIV-1 and emit a one-cycle tick on the wrap
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 receiver: synchronises the line, samples mid-bit, strobes each good byte.
module uart_rx_core
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 line,
    output logic [DATA_BITS-1:0] data,
    output logic                 done
);

    logic                 sync1, rx_s;
    rx_state_t            state, state_next;
    logic [TICK_CW-1:0]   tick_cnt, tick_next;
    logic [BIT_CW-1:0]    bit_cnt, bit_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic [DATA_BITS-1:0] data_next;
    logic                 done_next;
    // Cleared by a framing error so a held-low line is not taken as a new start
    logic                 armed, armed_next;

    // Two-flop synchroniser for the asynchronous serial input (idles high)
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= line;
            rx_s  <= sync1;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RX_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            data     <= '0;
            done     <= 1'b0;
            armed    <= 1'b1;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_next;
            bit_cnt  <= bit_next;
            shift    <= shift_next;
            data     <= data_next;
            done     <= done_next;
            armed    <= armed_next;
        end
    end

    // Next-state and datapath logic; every count advances only on a baud tick
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        data_next  = data;
        done_next  = 1'b0;
        armed_next = armed;
        case (state)
            RX_IDLE: begin
                if (rx_s) begin
                    armed_next = 1'b1;
                end else if (armed) begin
                    state_next = RX_START;
                    tick_next  = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (tick_cnt == MID_LAST) begin
                        tick_next  = '0;
                        bit_next   = '0;
                        state_next = rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_next = tick_cnt + TICK_CW'(1);
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_next  = '0;
                        shift_next = {rx_s, shift[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            state_next = RX_STOP;
                        end else begin
                            bit_next = bit_cnt + BIT_CW'(1);
                        end
                    end else begin
                        tick_next = tick_cnt + TICK_CW'(1);
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_next  = '0;
                        state_next = RX_IDLE;
                        if (rx_s) begin
                            data_next = shift;
                            done_next = 1'b1;
                        end else begin
                            armed_next = 1'b0;
                        end
                    end else begin
                        tick_next = tick_cnt + TICK_CW'(1);
                    end
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 transmitter: latches a byte on load while idle and shifts it out LSB first.
module uart_tx_core
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data,
    output logic                 line
);

    tx_state_t            state, state_next;
    logic [TICK_CW-1:0]   tick_cnt, tick_next;
    logic [BIT_CW-1:0]    bit_cnt, bit_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 line_next;

    // State, datapath and registered line output
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= TX_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            line     <= 1'b1;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_next;
            bit_cnt  <= bit_next;
            shift    <= shift_next;
            line     <= line_next;
        end
    end

    // Next-state logic; the line value is computed for the state being entered
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        line_next  = line;
        case (state)
            TX_IDLE: begin
                line_next = 1'b1;
                if (load) begin
                    shift_next = data;
                    tick_next  = '0;
                    state_next = TX_START;
                    line_next  = 1'b0;
                end
            end
            TX_START: begin
                if (tick) begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_next  = '0;
                        bit_next   = '0;
                        state_next = TX_DATA;
                        line_next  = shift[0];
                    end else begin
                        tick_next = tick_cnt + TICK_CW'(1);
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_next = '0;
                        if (bit_cnt == DATA_LAST) begin
                            state_next = TX_STOP;
                            line_next  = 1'b1;
                        end else begin
                            bit_next   = bit_cnt + BIT_CW'(1);
                            shift_next = {1'b0, shift[DATA_BITS-1:1]};
                            line_next  = shift[1];
                        end
                    end else begin
                        tick_next = tick_cnt + TICK_CW'(1);
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_next  = '0;
                        state_next = TX_IDLE;
                        line_next  = 1'b1;
                    end else begin
                        tick_next = tick_cnt + TICK_CW'(1);
                    end
                end
            end
            default: begin
                state_next = TX_IDLE;
                line_next  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/uart_loopback_top.sv
// UART echo: every correctly received byte is reported and retransmitted.
module uart_loopback_top #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [7:0] rx_data,
    output logic       rx_done
);

    logic tick;

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    uart_rx_core u_rx (
        .clk (clk),
        .rst (rst),
        .tick(tick),
        .line(uart_rx),
        .data(rx_data),
        .done(rx_done)
    );

    // Loopback: a byte arriving while TX is busy is simply not loaded
    uart_tx_core u_tx (
        .clk (clk),
        .rst (rst),
        .tick(tick),
        .load(rx_done),
        .data(rx_data),
        .line(uart_tx)
    );

endmodule

// File: tb/tb_uart_loopback_top.sv
// Bench for uart_loopback_top, run at a reduced clock rate so a bit is 64 clocks.
module tb_uart_loopback_top;

    localparam int unsigned CLK_FREQ = 614_400;  // divisor 4 at 9600 baud x16
    localparam int unsigned BIT_CLKS = 64;

    logic       clk;
    logic       rst;
    logic       uart_rx;
    logic       uart_tx;
    logic [7:0] rx_data;
    logic       rx_done;

    uart_loopback_top #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (9600),
        .OVERSAMPLE(16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .uart_rx(uart_rx),
        .uart_tx(uart_tx),
        .rx_data(rx_data),
        .rx_done(rx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state: what the line protocol says must come out
    logic [7:0] exp_rx[$];
    logic [9:0] exp_tx[$];
    logic [7:0] last_good = 8'h00;

    // Observations
    logic [7:0] rx_obs[$];
    logic [9:0] tx_obs[$];
    int  done_long = 0;
    logic prev_done = 1'b0;
    int  fall_cyc = 0;
    logic fall_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Frame as seen on the wire in time order: bit 0 is the start bit
    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction

    // Drive one frame; a good frame is expected back on rx_data and as an echo
    // (every gap used here is at least one idle bit, so no echo is dropped)
    task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned idle_bits);
        uart_rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_clks(BIT_CLKS);
        end
        uart_rx = stop;
        wait_clks(BIT_CLKS);
        uart_rx = 1'b1;
        wait_clks(BIT_CLKS * idle_bits);
        if (stop) begin
            exp_rx.push_back(b);
            exp_tx.push_back(frame_of(b));
            last_good = b;
        end
    endtask

    task automatic compare_queues(input string tag);
        check({tag, "_rx_count"}, 32'(rx_obs.size()), 32'(exp_rx.size()));
        for (int i = 0; i < rx_obs.size() && i < exp_rx.size(); i++)
            check($sformatf("%s_rx%0d", tag, i), 32'(rx_obs[i]), 32'(exp_rx[i]));
        check({tag, "_tx_count"}, 32'(tx_obs.size()), 32'(exp_tx.size()));
        for (int i = 0; i < tx_obs.size() && i < exp_tx.size(); i++)
            check($sformatf("%s_tx%0d", tag, i), 32'(tx_obs[i]), 32'(exp_tx[i]));
        check({tag, "_rx_data_hold"}, 32'(rx_data), 32'(last_good));
        rx_obs.delete();
        tx_obs.delete();
        exp_rx.delete();
        exp_tx.delete();
    endtask

    // rx_done monitor: capture strobed bytes, flag strobes longer than one clock
    always @(negedge clk) begin
        if (rx_done === 1'b1) rx_obs.push_back(rx_data);
        if (rx_done === 1'b1 && prev_done === 1'b1) done_long++;
        prev_done = rx_done;
    end

    // TX monitor: decode frames at mid-bit from the falling start edge
    initial begin : tx_mon
        logic [9:0] fr;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && uart_tx === 1'b0) begin
                fall_cyc  = cyc;
                fall_seen = 1'b1;
                repeat (BIT_CLKS / 2) @(negedge clk);
                fr[0] = uart_tx;
                for (int k = 1; k < 10; k++) begin
                    repeat (BIT_CLKS) @(negedge clk);
                    fr[k] = uart_tx;
                end
                tx_obs.push_back(fr);
            end
        end
    end

    initial begin : watchdog
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 80000 cycles");
        $fatal(1, "timeout");
    end

    initial begin : main
        int target;
        logic [7:0] b;
        rst     = 1'b0;
        uart_rx = 1'b1;
        wait_clks(5);
        check("reset_tx", 32'(uart_tx), 32'(1));
        check("reset_rx_data", 32'(rx_data), 32'(0));
        check("reset_rx_done", 32'(rx_done), 32'(0));
        rst = 1'b1;
        wait_clks(BIT_CLKS * 2);

        // Single byte, with the literal expected wire sequence 0,1,0,0,0,1,1,0,0,1
        send_frame(8'h31, 1'b1, 1);
        wait_clks(BIT_CLKS * 11);
        check("single_tx_seq", 32'(tx_obs.size() > 0 ? tx_obs[0] : 10'h0), 32'(10'b1001100010));
        compare_queues("single");

        // Ten consecutive bytes with one idle bit each
        for (int i = 0; i < 10; i++) send_frame(8'(8'h30 + i), 1'b1, 1);
        wait_clks(BIT_CLKS * 11);
        compare_queues("ten");

        // Short low glitch: start rejected at the mid-start resample
        uart_rx = 1'b0;
        wait_clks($urandom_range(4, 20));
        uart_rx = 1'b1;
        wait_clks(BIT_CLKS * 12);
        compare_queues("glitch");

        // Framing error: byte discarded, rx_data holds, no echo
        send_frame(8'h55, 1'b0, 2);
        wait_clks(BIT_CLKS * 11);
        compare_queues("framing");

        // Reset during TX bit 4 (0x0F has bit 4 = 0 so the line is low there)
        fall_seen = 1'b0;
        send_frame(8'h0F, 1'b1, 0);
        check("rst_tx_started", 32'(fall_seen), 32'(1));
        target = fall_cyc + BIT_CLKS * 5 + BIT_CLKS / 2;
        while (cyc < target) @(negedge clk);
        check("rst_tx_bit4_low", 32'(uart_tx), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx_high", 32'(uart_tx), 32'(1));
        wait_clks(4);
        check("rst_rx_data", 32'(rx_data), 32'(0));
        check("rst_rx_done", 32'(rx_done), 32'(0));
        rst = 1'b1;
        last_good = 8'h00;
        wait_clks(BIT_CLKS * 12);
        rx_obs.delete();
        tx_obs.delete();
        exp_rx.delete();
        exp_tx.delete();
        send_frame(8'hA5, 1'b1, 1);
        wait_clks(BIT_CLKS * 11);
        compare_queues("after_rst");

        // Random bytes with random idle gaps of 1..3 bits
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, $urandom_range(1, 3));
        end
        wait_clks(BIT_CLKS * 11);
        compare_queues("random");

        check("rx_done_width", 32'(done_long), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
